// File: rtl/cdru.sv
// cdru -- Conflict Detection Read Unit.
// One instance per bank. It arbitrates read requests from requesters i, d
// and c. At most one request is granted per cycle, and the grant is
// combinational in the request cycle. The winner drives the bank RAM read
// port. Each issued read is tracked through an RDLAT-deep tag pipeline, so
// the data that returns is flagged to the requester that issued it.
// Saturating starvation counters raise the priority of d or c when a
// higher-priority requester would otherwise lock them out.
//
// Parameters:
//   BANKBITS, WORDBITS  address split; the full address is BANKBITS+WORDBITS bits
//   DATABITS            RAM read data width
//   RDLAT               RAM read latency in cycles, 1..8
//   STARVELIM           consecutive denied cycles before a boost, 1..255
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   {i,d,c}_en / _addr / _grnt   requests, addresses, same-cycle grants
//   o_en, o_addr                 RAM read port
//   muxcode                      winner this cycle: 0=i, 1=d, 2=c
//   r_data -> rd_data            RAM read data, passed straight through
//   {i,d,c}_rvalid               rd_data belongs to that requester this cycle

// Starvation counter for one requester. It counts consecutive cycles in
// which the requester asks and is denied, and saturates at LIM. A grant or
// an idle cycle clears it.
module cdru_starve #(
   parameter int LIM = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic grnt,
   output logic boost
);
   localparam logic [7:0] LIM8 = 8'(LIM);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en && !grnt) begin
         if (cnt != LIM8)
            cnt <= cnt + 8'd1;
      end else
         cnt <= '0;
   end

   assign boost = (cnt == LIM8);
endmodule

module cdru #(
   parameter int BANKBITS  = 5,
   parameter int WORDBITS  = 9,
   parameter int DATABITS  = 32,
   parameter int RDLAT     = 2,
   parameter int STARVELIM = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_en,
   input  logic [BANKBITS+WORDBITS-1:0] i_addr,
   output logic                         i_grnt,
   input  logic                         d_en,
   input  logic [BANKBITS+WORDBITS-1:0] d_addr,
   output logic                         d_grnt,
   input  logic                         c_en,
   input  logic [BANKBITS+WORDBITS-1:0] c_addr,
   output logic                         c_grnt,
   output logic                         o_en,
   output logic [BANKBITS+WORDBITS-1:0] o_addr,
   output logic [1:0]                   muxcode,
   input  logic [DATABITS-1:0]          r_data,
   output logic [DATABITS-1:0]          rd_data,
   output logic                         i_rvalid,
   output logic                         d_rvalid,
   output logic                         c_rvalid
);
   typedef enum logic [1:0] {
      W_I = 2'd0,
      W_D = 2'd1,
      W_C = 2'd2
   } win_t;

   win_t win;
   logic d_boost, c_boost;

   cdru_starve #(.LIM(STARVELIM)) u_d_starve (
      .clk(clk), .rst(rst), .en(d_en), .grnt(d_grnt), .boost(d_boost));
   cdru_starve #(.LIM(STARVELIM)) u_c_starve (
      .clk(clk), .rst(rst), .en(c_en), .grnt(c_grnt), .boost(c_boost));

   // A boosted c outranks a boosted d. The fall-through case is c, so when
   // nobody requests, muxcode reads 2 and o_addr shows c_addr (a don't-care).
   always_comb begin
      win = W_C;
      if (c_en && c_boost)      win = W_C;
      else if (d_en && d_boost) win = W_D;
      else if (i_en)            win = W_I;
      else if (d_en)            win = W_D;
      else                      win = W_C;
   end

   always_comb begin
      o_addr = c_addr;
      case (win)
         W_I:     o_addr = i_addr;
         W_D:     o_addr = d_addr;
         default: o_addr = c_addr;
      endcase
   end

   assign muxcode = win;
   assign o_en    = i_en | d_en | c_en;
   assign i_grnt  = i_en && (win == W_I);
   assign d_grnt  = d_en && (win == W_D);
   assign c_grnt  = c_en && (win == W_C);

   // Return tag pipeline. Stage k holds the {valid, code} of the read that
   // was issued k cycles ago. Reset clears it, so reads in flight at reset
   // are dropped silently.
   logic [RDLAT:1]      vld_pipe;
   logic [RDLAT:1][1:0] code_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         code_pipe <= '0;
      end else begin
         vld_pipe[1]  <= o_en;
         code_pipe[1] <= muxcode;
         for (int k = 2; k <= RDLAT; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            code_pipe[k] <= code_pipe[k-1];
         end
      end
   end

   assign i_rvalid = vld_pipe[RDLAT] && (code_pipe[RDLAT] == 2'd0);
   assign d_rvalid = vld_pipe[RDLAT] && (code_pipe[RDLAT] == 2'd1);
   assign c_rvalid = vld_pipe[RDLAT] && (code_pipe[RDLAT] == 2'd2);
   assign rd_data  = r_data;
endmodule
